// File: rtl/led_pkg.sv
// Shared types and defaults for the LED strip frame feeder.
// Two pixel banks of up to 256 entries each, addressed as {bank, idx}.
package led_pkg;

  localparam int DEF_NUM_LEDS     = 144;
  localparam int DEF_LATCH_CYCLES = 2400;

  typedef logic [23:0] pixel_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_FETCH   = 2'd1;
  localparam state_t ST_PRESENT = 2'd2;
  localparam state_t ST_LATCH   = 2'd3;

endpackage

// File: rtl/led_pixel_ram.sv
// 512x24 simple dual-port pixel store: one write port, one registered read port.
// No reset on the array or read register so the tools can map it onto block RAM.
module led_pixel_ram
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [8:0] waddr,
  input  pixel_t     wdata,
  input  logic       re,
  input  logic [8:0] raddr,
  output pixel_t     rdata
);

  pixel_t mem [0:511];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/led_frame_feeder.sv
// Double-buffered frame feeder: host writes the back bank, commit swaps banks at
// the next idle point, and the front bank is streamed pixel by pixel to a strip driver.
module led_frame_feeder
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        commit,
  input  logic        pix_req,
  output logic        pix_valid,
  output logic [23:0] rgb,
  output logic        pix_last,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy
);

  localparam int            CW       = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [7:0]    LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LATCH_CYCLES - 1);

  state_t        state_reg, state_next;
  logic          front_sel_reg, front_sel_next;
  logic          pending_reg, pending_next;
  logic [7:0]    idx_reg, idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pix_valid_reg, pix_valid_next;

  logic   wr_ok;
  pixel_t ram_q;

  always_comb begin
    state_next     = state_reg;
    front_sel_next = front_sel_reg;
    pending_next   = pending_reg | commit;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    pix_valid_next = pix_valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pending_reg) begin
          state_next     = ST_FETCH;
          front_sel_next = ~front_sel_reg;
          pending_next   = commit;
          idx_next       = 8'd0;
        end
      end
      ST_FETCH: begin
        state_next     = ST_PRESENT;
        pix_valid_next = 1'b1;
      end
      ST_PRESENT: begin
        if (pix_req) begin
          pix_valid_next = 1'b0;
          if (idx_reg < LAST_IDX) begin
            idx_next   = idx_reg + 8'd1;
            state_next = ST_FETCH;
          end else begin
            cnt_next   = '0;
            state_next = ST_LATCH;
          end
        end
      end
      default: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      front_sel_reg <= 1'b0;
      pending_reg   <= 1'b0;
      idx_reg       <= 8'd0;
      cnt_reg       <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      front_sel_reg <= front_sel_next;
      pending_reg   <= pending_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      pix_valid_reg <= pix_valid_next;
    end
  end

  // Out-of-range addresses are dropped here, so the bank never aliases.
  assign wr_ok = wr_en && !rst && ({1'b0, wr_addr} < 9'(NUM_LEDS));

  led_pixel_ram u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr ({~front_sel_reg, wr_addr}),
    .wdata (wr_data),
    .re    (state_reg == ST_FETCH),
    .raddr ({front_sel_reg, idx_reg}),
    .rdata (ram_q)
  );

  // The RAM read register only updates in FETCH, so it already holds through PRESENT.
  assign pix_valid   = pix_valid_reg;
  assign rgb         = pix_valid_reg ? ram_q : 24'd0;
  assign pix_last    = pix_valid_reg && (idx_reg == LAST_IDX);
  assign frame_start = (state_reg == ST_FETCH) && (idx_reg == 8'd0);
  assign frame_done  = (state_reg == ST_LATCH) && (cnt_reg == LAST_CNT);
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_led_frame_feeder.sv
// Bench for led_frame_feeder: random pixel images and strip back-pressure, checked
// against a two-bank image model with a pending-commit flag.
module tb_led_frame_feeder;

  localparam int N  = 144;
  localparam int LC = 2400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [23:0] wr_data = 24'd0;
  logic        commit = 1'b0;
  logic        pix_req = 1'b0;
  logic        pix_valid, pix_last, frame_start, frame_done, busy;
  logic [23:0] rgb;

  always #5 clk = ~clk;

  led_frame_feeder #(.NUM_LEDS(N), .LATCH_CYCLES(LC)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .pix_req     (pix_req),
    .pix_valid   (pix_valid),
    .rgb         (rgb),
    .pix_last    (pix_last),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  int          frames = 0;
  logic [23:0] model_mem [0:511];
  bit          model_front = 1'b0;
  bit          model_pending = 1'b0;
  bit          again;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int maddr(input bit b, input int a);
    return (b ? 256 : 0) + a;
  endfunction

  task automatic put_px(input int a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = 8'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
    if (a < N) model_mem[maddr(!model_front, a)] = d;
  endtask

  task automatic fill_back();
    for (int a = 0; a < N; a++) put_px(a, 24'($urandom));
    for (int k = 0; k < 3; k++) put_px(N + $urandom_range(0, 255 - N), 24'($urandom));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_rgb"},   32'(rgb), 32'd0);
    chk({tag, "_last"},  32'(pix_last), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_fd"},    32'(frame_done), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // Commit from IDLE: pending after the sampling edge, FETCH one edge later.
  task automatic do_commit(input bit dbl);
    commit = 1'b1;
    step();
    commit = dbl;
    chk("commit_fs_early", 32'(frame_start), 32'd0);
    chk("commit_busy_early", 32'(busy), 32'd0);
    step();
    commit = 1'b0;
    chk("commit_fs", 32'(frame_start), 32'd1);
    chk("commit_busy", 32'(busy), 32'd1);
    chk("commit_valid", 32'(pix_valid), 32'd0);
    model_front   = !model_front;
    model_pending = dbl;
  endtask

  // Entered on the first FETCH cycle of a frame; streams and checks the whole frame.
  task automatic run_frame(input int stall_max, input bit hold_req, input int stall50_at,
                           input int mid_at, input int rst_at, output bit restarted);
    logic [23:0] exp_px;
    int w, d, c;
    bit seen;
    restarted = 1'b0;
    pix_req = hold_req;
    for (int i = 0; i < N; i++) begin
      w = 0;
      while (!pix_valid && w < 4) begin
        step();
        w++;
      end
      chk("pix_latency", 32'(w), 32'd1);
      exp_px = model_mem[maddr(model_front, i)];
      chk("rgb", 32'(rgb), 32'(exp_px));
      chk("pix_last", 32'(pix_last), 32'(i == N - 1));
      if (i == rst_at) begin
        rst = 1'b1; commit = 1'b1; wr_en = 1'b1; wr_addr = 8'd3; wr_data = 24'($urandom);
        pix_req = 1'b0;
        step();
        rst = 1'b0; commit = 1'b0; wr_en = 1'b0;
        check_quiet("rst_mid");
        model_front = 1'b0;
        model_pending = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < LC + 20; k++) begin
          step();
          if (frame_done || busy || frame_start) seen = 1'b1;
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        $display("frame aborted by reset at pixel %0d", i);
        return;
      end
      if (i == mid_at) begin
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 24'h123456; commit = 1'b1;
        step();
        wr_en = 1'b0;
        chk("mid_hold1", 32'(rgb), 32'(exp_px));
        step();
        commit = 1'b0;
        chk("mid_hold2", 32'(rgb), 32'(exp_px));
        model_mem[maddr(!model_front, 5)] = 24'h123456;
        model_pending = 1'b1;
      end
      if (hold_req) begin
        step();
      end else begin
        d = (i == stall50_at) ? 50 : $urandom_range(0, stall_max);
        for (int k = 0; k < d; k++) begin
          step();
          chk("hold_rgb", 32'(rgb), 32'(exp_px));
          chk("hold_valid", 32'(pix_valid), 32'd1);
          chk("hold_last", 32'(pix_last), 32'(i == N - 1));
        end
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
      end
      chk("valid_drop", 32'(pix_valid), 32'd0);
    end
    c = 1;
    while (!frame_done && c < LC + 10) begin
      step();
      c++;
    end
    chk("latch_len", 32'(c), 32'(LC));
    chk("done_busy", 32'(busy), 32'd1);
    pix_req = 1'b0;
    step();
    chk("idle_done", 32'(frame_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_fs", 32'(frame_start), 32'd0);
    frames++;
    $display("frame %0d complete bank=%0d pending=%0d", frames, model_front, model_pending);
    if (model_pending) begin
      step();
      chk("restart_fs", 32'(frame_start), 32'd1);
      model_front   = !model_front;
      model_pending = 1'b0;
      restarted     = 1'b1;
    end else begin
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (frame_start || busy) seen = 1'b1;
      end
      chk("no_restart", 32'(seen), 32'd0);
    end
  endtask

  initial begin
    repeat (3) step();
    check_quiet("reset");
    rst = 1'b0;
    step();
    check_quiet("post_reset");

    // Frame A with marker pixels, strip consuming continuously.
    fill_back();
    put_px(0, 24'h0000FF);
    put_px(1, 24'h00FF00);
    put_px(N - 1, 24'hFF0000);
    put_px(200, 24'hABCDEF);
    do_commit(1'b0);
    run_frame(0, 1'b1, -1, -1, -1, again);
    chk("a_no_again", 32'(again), 32'd0);

    // Frame B with back-pressure and a long stall; double commit replays A afterwards.
    fill_back();
    do_commit(1'b1);
    run_frame(3, 1'b0, 10, -1, -1, again);
    chk("b_again", 32'(again), 32'd1);
    run_frame(0, 1'b0, -1, -1, -1, again);

    // Partial rewrite of B, plus a deferred commit issued mid-frame.
    for (int k = 0; k < 6; k++) put_px($urandom_range(0, N - 1), 24'($urandom));
    do_commit(1'b0);
    run_frame(2, 1'b0, -1, 2, -1, again);
    chk("mid_again", 32'(again), 32'd1);
    run_frame(1, 1'b0, -1, -1, -1, again);

    // Reset mid-frame; storage must survive and the ignored write must not land.
    for (int k = 0; k < 4; k++) put_px($urandom_range(0, N - 1), 24'($urandom));
    do_commit(1'b0);
    run_frame(1, 1'b0, -1, -1, 70, again);
    do_commit(1'b0);
    run_frame(0, 1'b1, -1, -1, -1, again);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/led_frame_feeder.md
LED_FRAME_FEEDER -- requirements
Module: led_frame_feeder

Interface
REQ-001 Parameter NUM_LEDS, 144, number of pixels per frame (1..256).
REQ-002 Parameter LATCH_CYCLES, 2400, idle clk cycles after last pixel (50 us at 48 MHz).
REQ-003 clk  in  1  clock; all logic on posedge clk.
REQ-004 rst  in  1  reset rst, synchronous, active-high.
REQ-005 wr_en  in  1  write strobe for back-bank pixel store.
REQ-006 wr_addr  in  8  pixel index to write.
REQ-007 wr_data  in  24  pixel colour, GRB order, MSB first as sent to strip.
REQ-008 commit  in  1  one-cycle request to display the back bank as the next frame.
REQ-009 pix_req  in  1  downstream strip driver consumes the presented pixel.
REQ-010 pix_valid  out  1  rgb holds a valid pixel.
REQ-011 rgb  out  24  current pixel colour.
REQ-012 pix_last  out  1  presented pixel is index NUM_LEDS-1.
REQ-013 frame_start  out  1  one-cycle pulse when a frame begins.
REQ-014 frame_done  out  1  one-cycle pulse when the latch gap ends.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Storage SHALL be two banks of NUM_LEDS x 24; front bank (front_sel) is read, back bank (~front_sel) is written.
REQ-017 Writes with wr_en=1 and wr_addr<NUM_LEDS SHALL update the back bank on that edge in any state; wr_addr>=NUM_LEDS SHALL be ignored.
REQ-018 commit=1 SHALL set a pending flag on the next edge; repeated commits while pending SHALL have no extra effect.
REQ-019 FSM states: IDLE, FETCH, PRESENT, LATCH.
REQ-020 IDLE: if pending, next edge SHALL go to FETCH, toggle front_sel, clear pending (kept set if commit=1 that same cycle), zero idx.
REQ-021 frame_start SHALL be high exactly the first cycle in FETCH with idx=0.
REQ-022 FETCH: issue synchronous read of {front_sel, idx}; next edge SHALL load rgb, set pix_valid, enter PRESENT.
REQ-023 PRESENT: rgb and pix_valid SHALL hold until pix_req=1; pix_req outside PRESENT SHALL be ignored.
REQ-024 PRESENT with pix_req=1: if idx<NUM_LEDS-1, idx increments and next state FETCH; else next state LATCH; pix_valid drops on that edge.
REQ-025 pix_last = pix_valid and idx==NUM_LEDS-1.
REQ-026 LATCH: counter runs LATCH_CYCLES cycles; on the last, frame_done pulses and next state is IDLE.
REQ-027 Latency: commit sampled at edge k -> FETCH after k+1 -> pix_valid with pixel 0 after k+2.
REQ-028 Back bank is not copied on swap; after a swap it holds the prior displayed frame until rewritten.
REQ-029 Commit during FETCH/PRESENT/LATCH SHALL be deferred to the next IDLE; no frame is ever truncated.
REQ-030 idx and counter widths SHALL cover NUM_LEDS-1 and LATCH_CYCLES-1 without wrap.

Reset
REQ-031 rst SHALL force IDLE, front_sel=0, pending=0, idx=0, counter=0, rgb=0, pix_valid=0, frame_start=0, frame_done=0, busy=0 on the next edge, including mid-frame.
REQ-032 Pixel storage contents SHALL NOT be reset.
REQ-033 commit or wr_en asserted during rst SHALL be ignored.

Structure
REQ-034 Package led_pkg SHALL hold the state enum, default NUM_LEDS and LATCH_CYCLES, and the 24-bit pixel type.
REQ-035 One sub-module led_pixel_ram: 512x24 simple dual-port, sync write, 1-cycle sync read, address {bank, idx[7:0]}, inferable as EBR.

Verification
REQ-036 Write idx0=0x0000FF, idx1=0x00FF00, idx143=0xFF0000, commit -> frame_start 1 cycle after commit edge, pixels stream 0..143, pix_last only on 0xFF0000.
REQ-037 pix_req held high continuously -> one pixel per 2 cycles, 144 pixels, then 2400 idle cycles, frame_done, busy low.
REQ-038 pix_req withheld 50 cycles in PRESENT -> rgb/pix_valid stable all 50 cycles, no idx advance.
REQ-039 Write idx5=0x123456 and commit mid-frame -> current frame unchanged at idx5; next frame starts right after frame_done cycle and shows 0x123456 at idx5.
REQ-040 wr_addr=200 with wr_en -> no bank change; rst at pixel 70 -> all outputs reset next edge, no frame_done.
